// File: rtl/noc_pm_out_arb_if.sv
// Handshake bundle between the local requesters / FIFO write side and noc_pm_out_arb.
interface noc_pm_out_arb_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]                 req_valid_i;
    logic [NUM_REQ-1:0]                 req_last_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]                 req_ready_o;
    logic                               out_valid_o;
    logic                               out_last_o;
    logic [DATA_WIDTH-1:0]              out_data_o;
    logic                               out_ready_i;
    logic [NUM_REQ-1:0]                 grant_o;
    logic                               err_o;

    modport slave (
        input  req_valid_i, req_last_i, req_data_i, out_ready_i,
        output req_ready_o, out_valid_o, out_last_o, out_data_o, grant_o, err_o
    );

    modport master (
        output req_valid_i, req_last_i, req_data_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_last_o, out_data_o, grant_o, err_o
    );
endinterface

// File: rtl/noc_pm_out_arb.sv
// Packet-granular round-robin arbiter onto the PM's single NoC output register.
// Optional NOC_PM_ARB_PRIO0_EN: requester 0 gets strict priority, round-robin over the rest.
`ifndef NOC_ASYNC_FIFO_PACKET_SIZE
`define NOC_ASYNC_FIFO_PACKET_SIZE 32
`endif

module noc_pm_out_arb #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = `NOC_ASYNC_FIFO_PACKET_SIZE,
    parameter int MAX_FLITS  = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    noc_pm_out_arb_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_FLITS + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [IDX_W-1:0]      gidx_q, gidx_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ov_q, ov_d;
    logic                  ol_q, ol_d;
    logic [DATA_WIDTH-1:0] od_q, od_d;
    logic                  err_q, err_d;

    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic                  can_take, accept, cap, g_last;
    logic [NUM_REQ-1:0]    ready;

    // Rotating search starting just after the last serviced requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef NOC_PM_ARB_PRIO0_EN
        if (bus.req_valid_i[0]) begin
            win_found = 1'b1;
        end else begin
            for (int i = 1; i < NUM_REQ; i++) begin
                int idx;
                idx = ((int'(rr_q) - 1 + i) % (NUM_REQ - 1)) + 1;
                if (!win_found && bus.req_valid_i[idx]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(idx);
                end
            end
        end
`else
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (!win_found && bus.req_valid_i[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
`endif
    end

    assign can_take = (state_q == GRANT) && (!ov_q || bus.out_ready_i);
    assign ready    = grant_q & {NUM_REQ{can_take}};
    assign accept   = |(ready & bus.req_valid_i);
    assign cap      = (cnt_q == CNT_W'(MAX_FLITS - 1));
    assign g_last   = bus.req_last_i[gidx_q];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        ol_d    = ol_q;
        od_d    = od_q;
        err_d   = 1'b0;
        if (ov_q && bus.out_ready_i)
            ov_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = GRANT;
                    gidx_d           = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    cnt_d            = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    ov_d  = 1'b1;
                    od_d  = bus.req_data_i[gidx_q];
                    ol_d  = g_last | cap;
                    err_d = !g_last && cap;
                    cnt_d = cnt_q + 1'b1;
                    // Packet end, natural or truncated, releases the grant.
                    if (g_last || cap) begin
                        state_d = IDLE;
                        grant_d = '0;
`ifdef NOC_PM_ARB_PRIO0_EN
                        if (gidx_q != '0)
                            rr_d = gidx_q;
`else
                        rr_d = gidx_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rr_q    <= IDX_W'(NUM_REQ - 1);
            gidx_q  <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            od_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
            od_q    <= od_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.out_valid_o = ov_q;
    assign bus.out_last_o  = ol_q;
    assign bus.out_data_o  = od_q;
    assign bus.grant_o     = grant_q;
    assign bus.err_o       = err_q;
endmodule
